// File: rtl/recovery_request_arbiter.sv
// Recovery request arbiter: merges RW-stage and commit-stage recovery
// requests, keeps the oldest RW request while the recovery manager is busy,
// and issues one registered request (pulse + payload) per recovery.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | nothing held
// HOLD   | an RW request is held in the pending buffer
// ISSUED | issued last cycle; downstream has not raised busy yet, so
//        | issue is blocked for this one cycle
module recovery_request_arbiter #(
    parameter int AL_INDEX_WIDTH = 6,
    parameter int PC_WIDTH       = 32,
    parameter int REFETCH_WIDTH  = 3,
    parameter int CAUSE_WIDTH    = 4,
    parameter int HIST_WIDTH     = 10,
    parameter int CSR_REFETCH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AL_INDEX_WIDTH-1:0] alHeadPtr,
    input  logic                      unableToStartRecovery,
    input  logic                      rwReqValid,
    input  logic [AL_INDEX_WIDTH-1:0] rwReqPtr,
    input  logic [PC_WIDTH-1:0]       rwReqPC,
    input  logic [REFETCH_WIDTH-1:0]  rwReqRefetch,
    input  logic [HIST_WIDTH-1:0]     rwReqHist,
    input  logic                      cmReqValid,
    input  logic [PC_WIDTH-1:0]       cmReqPC,
    input  logic [REFETCH_WIDTH-1:0]  cmReqRefetch,
    input  logic [CAUSE_WIDTH-1:0]    cmReqCause,
    output logic                      cmReqAccept,
    output logic                      exceptionDetectedInRwStage,
    output logic                      exceptionDetectedInCommitStage,
    output logic [PC_WIDTH-1:0]       recoveredPC,
    output logic [REFETCH_WIDTH-1:0]  refetchType,
    output logic [CAUSE_WIDTH-1:0]    recoveryCause,
    output logic [HIST_WIDTH-1:0]     recoveredBrHistory,
    output logic [AL_INDEX_WIDTH-1:0] exceptionOpPtr,
    output logic                      pendingValid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        ISSUED = 2'd2
    } stateType;

    stateType state;
    stateType nextState;

    logic [AL_INDEX_WIDTH-1:0] pendPtr;
    logic [PC_WIDTH-1:0]       pendPC;
    logic [REFETCH_WIDTH-1:0]  pendRefetch;
    logic [HIST_WIDTH-1:0]     pendHist;

    logic [AL_INDEX_WIDTH-1:0] pendAge;
    logic [AL_INDEX_WIDTH-1:0] rwAge;
    logic                      pendStale;
    logic                      pendLive;
    logic                      takeRw;
    logic                      candValid;
    logic [AL_INDEX_WIDTH-1:0] candPtr;
    logic [PC_WIDTH-1:0]       candPC;
    logic [REFETCH_WIDTH-1:0]  candRefetch;
    logic [HIST_WIDTH-1:0]     candHist;
    logic                      issueAllowed;
    logic                      commitIssue;
    logic                      rwIssue;

    // Age comparison and candidate selection; a pending entry whose age hit
    // the top value has been passed by the head and no longer exists.
    always_comb begin
        pendAge      = pendPtr - alHeadPtr;
        rwAge        = rwReqPtr - alHeadPtr;
        pendStale    = pendingValid && (pendAge == '1);
        pendLive     = pendingValid && !pendStale;
        takeRw       = rwReqValid && (!pendLive || (rwAge < pendAge));
        candValid    = pendLive || rwReqValid;
        candPtr      = takeRw ? rwReqPtr     : pendPtr;
        candPC       = takeRw ? rwReqPC      : pendPC;
        candRefetch  = takeRw ? rwReqRefetch : pendRefetch;
        candHist     = takeRw ? rwReqHist    : pendHist;
        issueAllowed = !unableToStartRecovery && (state != ISSUED);
        commitIssue  = cmReqValid && issueAllowed;
        rwIssue      = !commitIssue && candValid && issueAllowed;
    end

    // Reset holds the combinational accept low as well.
    assign cmReqAccept = commitIssue & ~rst;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = IDLE;
        case (state)
            IDLE, HOLD: begin
                if (commitIssue || rwIssue) begin
                    nextState = ISSUED;
                end else if (candValid) begin
                    nextState = HOLD;
                end else begin
                    nextState = IDLE;
                end
            end
            ISSUED: begin
                nextState = candValid ? HOLD : IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Pending buffer: any issue empties it (a commit flushes younger RW ops),
    // otherwise it keeps the oldest candidate seen so far.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pendingValid <= 1'b0;
            pendPtr      <= '0;
            pendPC       <= '0;
            pendRefetch  <= '0;
            pendHist     <= '0;
        end else if (commitIssue || rwIssue) begin
            pendingValid <= 1'b0;
        end else begin
            pendingValid <= candValid;
            if (candValid) begin
                pendPtr     <= candPtr;
                pendPC      <= candPC;
                pendRefetch <= candRefetch;
                pendHist    <= candHist;
            end
        end
    end

    // Registered issue: single-cycle pulse, payload held between issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exceptionDetectedInRwStage     <= 1'b0;
            exceptionDetectedInCommitStage <= 1'b0;
            recoveredPC                    <= '0;
            refetchType                    <= '0;
            recoveryCause                  <= '0;
            recoveredBrHistory             <= '0;
            exceptionOpPtr                 <= '0;
        end else begin
            exceptionDetectedInRwStage     <= 1'b0;
            exceptionDetectedInCommitStage <= 1'b0;
            if (commitIssue) begin
                exceptionDetectedInCommitStage <= 1'b1;
                recoveredPC                    <= cmReqPC;
                refetchType                    <= cmReqRefetch;
                recoveryCause                  <= cmReqCause;
                recoveredBrHistory             <= '0;
                exceptionOpPtr                 <= alHeadPtr;
            end else if (rwIssue) begin
                exceptionDetectedInRwStage <= 1'b1;
                recoveredPC                <= candPC;
                refetchType                <= candRefetch;
                recoveryCause              <= '0;
                recoveredBrHistory         <= candHist;
                exceptionOpPtr             <= candPtr;
            end
        end
    end

    // RW stage never requests a CSR-target refetch.
    noCsrRefetchFromRw: assert property (@(posedge clk) disable iff (rst)
        !(rwReqValid && (rwReqRefetch == REFETCH_WIDTH'(CSR_REFETCH))));

    // The head cannot pass a held request unless a commit recovery flushes it.
    noStalePending: assert property (@(posedge clk) disable iff (rst)
        !(pendStale && !commitIssue));

endmodule
